dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
//
// PURPOSE
//   Multi-cycle data-memory responder: the memory side of the pipeline's data-memory access interface.
//   Accepts one read or write request per handshake, holds it for a configurable latency, then
//   returns a single-cycle response. The pipeline's MEM stage drives requests and holds them while
//   req_ready is low.
//   Word-organised 16-bit storage, byte addresses, no cache; sized for replacement of the ideal memory.
//
// PARAMETERS
//   DEPTH_LOG2  10  log2 of storage depth in 16-bit words (1024 words)
//   LATENCY      4  cycles from accept edge to rsp_valid; legal range 1..15 (4-bit counter)
//
// PORTS
//   clk         in   1   single clock, rising edge
//   rst_n       in   1   reset, asynchronous, active-low
//   req_valid   in   1   request present
//   req_wr      in   1   1 = write, 0 = read
//   req_addr    in  16   byte address; word index = req_addr[DEPTH_LOG2:1]
//   req_wdata   in  16   write data
//   req_ready   out  1   responder can accept this cycle
//   rsp_valid   out  1   one-cycle response strobe
//   rsp_rdata   out 16   read data, valid only with rsp_valid && !wr; 16'h0000 otherwise
//   rsp_err     out  1   error flag, qualified by rsp_valid (see CONFIGURATION)
//   busy        out  1   request outstanding (state != IDLE); used by hazard logic as stall
//
// BEHAVIOUR
//   - States: IDLE, WAIT. Registers: state, cnt[3:0], wr_q, idx_q, wdata_q, err_q.
//   - Accept = req_valid && req_ready, sampled on rising clk. req_ready = IDLE || (WAIT && cnt==0).
//   - On accept: latch wr/idx/wdata/err, cnt <= LATENCY-1, state <= WAIT.
//   - rsp_valid = WAIT && cnt==0 (combinational from state regs). Asserts exactly LATENCY cycles
//     after the accept edge (cycle 1 = first cycle after the edge).
//   - WAIT && cnt!=0: cnt decrements each edge; request inputs are ignored.
//   - Response edge (rsp_valid high): write commits mem[idx_q] <= wdata_q unless err_q; state <= IDLE,
//     or, if a new accept occurs on the same edge, the new request is latched and state stays WAIT
//     (back-to-back, one request per LATENCY cycles).
//   - Read data: rsp_rdata = mem[idx_q] during rsp_valid; a read accepted in a write's response cycle
//     returns the newly written data.
//   - Address: bits above DEPTH_LOG2 are ignored (aliasing wrap-around); bit 0 ignored unless checking.
//   - Reset (any time, incl. mid-WAIT): state=IDLE, cnt=0, rsp_valid=0, rsp_err=0, busy=0,
//     req_ready=1 after release. Pending request is dropped, including an uncommitted write.
//     Storage contents are NOT reset.
//   - Request inputs are ignored when req_ready=0; the requester must hold them stable.
//
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined:   req_addr[0]==1 sets err_q at accept. The response gives
//     rsp_err=1 and rsp_rdata=0; the write is suppressed. Latency is unchanged.
//   DMEM_ALIGN_CHECK_EN undefined: rsp_err tied 0; req_addr[0] ignored. No error register.
//
// TESTING  (LATENCY=4, DEPTH_LOG2=10 unless stated)
//   1 wr 0x0010=0xBEEF then rd 0x0010 -> rsp_valid 4 cycles after each accept; rd returns 0xBEEF.
//   2 rd 0x0810 after test 1 -> returns 0xBEEF (alias of word 0x008).
//   3 back-to-back: wr 0x0020=0x1234, next req rd 0x0020 held at rsp cycle -> accepted same edge;
//     rd returns 0x1234; req_ready low 3 cycles between.
//   4 wr 0x0030=0xAAAA, rst_n low at cycle 2 of WAIT -> outputs reset immediately; later rd 0x0030
//     returns prior contents (not 0xAAAA).
//   5 macro on: wr 0x0041=0x5555 -> rsp_err=1 with rsp_valid; rd 0x0040 shows unchanged word;
//     macro off: same write lands at 0x0040, rsp_err=0.
//   6 LATENCY=1: rd every cycle with req_valid held -> rsp_valid every cycle, req_ready constant 1.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory access bus between the pipeline MEM stage (master) and the
// memory responder (slave). It carries the request handshake and the
// single-cycle response.
interface dmem_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with word-organised 16-bit storage.
// It accepts one request per handshake and holds it for LATENCY cycles.
// It then returns a one-cycle response, and a write commits on that same
// response edge. Byte addresses are used: the word index is
// req_addr[DEPTH_LOG2:1], and the higher address bits alias.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, an odd
// address flags rsp_err and suppresses the access.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4   // 1..15
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic                    err_q;
  logic [15:0]             mem [DEPTH];

  logic rsp_fire;
  logic accept;
  logic commit;

  assign rsp_fire = (state_q == WAIT) && (cnt_q == 4'd0);
  assign accept   = bus.req_valid && bus.req_ready;
  assign commit   = rsp_fire && wr_q && !err_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[15:DEPTH_LOG2+1];

  // Capture the alignment error of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= bus.req_addr[0];
  end

  assign bus.rsp_err = rsp_fire && err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[15:DEPTH_LOG2+1], bus.req_addr[0]};

  assign err_q       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a response returns to IDLE unless a new request is accepted on the same edge.
  always_comb begin
    // NOTE: assign the default first so that no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)               state_d = WAIT;
      WAIT: if (rsp_fire && !accept)  state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Latency counter and the captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
    end else if (accept) begin
      cnt_q   <= CNT_INIT;
      wr_q    <= bus.req_wr;
      idx_q   <= bus.req_addr[DEPTH_LOG2:1];
      wdata_q <= bus.req_wdata;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q   <= cnt_q - 4'd1;
    end
  end

  // Storage write that commits on the response edge.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; its contents survive rst_n, and only the pending request is dropped.
    if (commit) mem[idx_q] <= wdata_q;
  end

  assign bus.req_ready = (state_q == IDLE) || rsp_fire;
  assign bus.rsp_valid = rsp_fire;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_rdata = (rsp_fire && !wr_q && !err_q) ? mem[idx_q] : 16'h0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. It uses a queue scoreboard and a
// small behavioural memory model. A second instance with LATENCY=1 covers
// the one-request-per-cycle case.
module tb_dmem_responder;

  localparam int LAT = 4;
  localparam int DL  = 10;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus  ();
  dmem_if bus1 ();

  dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [DL-1:0] idx;
    logic [15:0]   wdata;
    logic          err;
    logic          known;
    logic [15:0]   rdata;
    int            acc;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model [int];
  exp_t        mon_e;
  exp_t        new_e;
  logic [15:0] last_rdata;
  logic        last_err;

  always @(posedge clk) cyc++;

  // Monitor: pop and compare responses first, then record any accept on the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid) begin
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        if (sb.size() == 0) begin
          check("spurious_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_latency", 32'(cyc - mon_e.acc), 32'(LAT - 1));
          check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
          if (mon_e.wr || mon_e.err)
            check("rsp_rdata_zero", 32'(bus.rsp_rdata), 32'd0);
          else if (mon_e.known)
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rdata));
          if (mon_e.wr && !mon_e.err) model[int'(mon_e.idx)] = mon_e.wdata;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        new_e.wr    = bus.req_wr;
        new_e.idx   = bus.req_addr[DL:1];
        new_e.wdata = bus.req_wdata;
        new_e.err   = ALIGN && bus.req_addr[0];
        new_e.known = model.exists(int'(new_e.idx));
        new_e.rdata = new_e.known ? model[int'(new_e.idx)] : 16'h0000;
        new_e.acc   = cyc + 1;
        sb.push_back(new_e);
      end
    end
  end

  // Issue one request and hold it until it is accepted; returns the number of stall cycles.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output int waited);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [15:0] exp_rd;
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_wdata  = 16'h0000;
    bus1.req_valid = 1'b0;
    bus1.req_wr    = 1'b0;
    bus1.req_addr  = 16'h0000;
    bus1.req_wdata = 16'h0000;

    // Reset state
    #12;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // 1: write then read
    do_req(1'b1, 16'h0010, 16'hBEEF, w);
    check("t1_busy", 32'(bus.busy), 32'd1);
    drain();
    do_req(1'b0, 16'h0010, 16'h0000, w);
    drain();
    check("t1_rd", 32'(last_rdata), 32'h0000BEEF);

    // 2: aliasing above DEPTH_LOG2
    do_req(1'b0, 16'h0810, 16'h0000, w);
    drain();
    check("t2_alias", 32'(last_rdata), 32'h0000BEEF);

    // 3: back-to-back, read accepted on the write's response edge
    do_req(1'b1, 16'h0020, 16'h1234, w);
    do_req(1'b0, 16'h0020, 16'h0000, w);
    check("t3_stall_cycles", 32'(w), 32'd3);
    drain();
    check("t3_rd", 32'(last_rdata), 32'h00001234);

    // 4: reset in the middle of a pending write drops it
    do_req(1'b1, 16'h0030, 16'h1111, w);
    drain();
    do_req(1'b1, 16'h0030, 16'hAAAA, w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4_busy",      32'(bus.busy),      32'd0);
    check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t4_rsp_err",   32'(bus.rsp_err),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("t4_ready", 32'(bus.req_ready), 32'd1);
    do_req(1'b0, 16'h0030, 16'h0000, w);
    drain();
    check("t4_rd_kept", 32'(last_rdata), 32'h00001111);

    // 5: misaligned write
    do_req(1'b1, 16'h0040, 16'h7777, w);
    drain();
    do_req(1'b1, 16'h0041, 16'h5555, w);
    drain();
    check("t5_err", 32'(last_err), 32'(ALIGN));
    do_req(1'b0, 16'h0040, 16'h0000, w);
    drain();
    exp_rd = ALIGN ? 16'h7777 : 16'h5555;
    check("t5_rd", 32'(last_rdata), 32'(exp_rd));

    // 6: LATENCY=1 instance, one request every cycle with req_valid held
    bus1.req_valid = 1'b1;
    bus1.req_wr    = 1'b1;
    bus1.req_addr  = 16'h0100;
    bus1.req_wdata = 16'hA000;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("l1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
        check("l1_rdata", 32'(bus1.rsp_rdata),
              (i - 1 < 4) ? 32'd0 : 32'(16'hA000 + 16'(i - 5)));
      end
      if (i < 8) check("l1_ready", 32'(bus1.req_ready), 32'd1);
      @(posedge clk); #1;
      if (i + 1 < 8) begin
        bus1.req_wr    = (i + 1 < 4);
        bus1.req_addr  = 16'h0100 + 16'(2 * ((i + 1) % 4));
        bus1.req_wdata = 16'hA000 + 16'((i + 1) % 4);
      end else begin
        bus1.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("l1_idle", 32'(bus1.rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
